// File: rtl/sa_inst_issuer_if.sv
// Host/array-side bundle for sa_inst_issuer: FIFO push port, status, slot flag and issued word.
// Carries issued_cnt only when SA_INST_ISSUER_COUNT_EN is defined.
interface sa_inst_issuer_if #(
    parameter int unsigned INST_BITS = 32,
    parameter int unsigned DEPTH     = 16
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic                 wr_en;
    logic [INST_BITS-1:0] wr_inst;
    logic                 flush;
    logic                 full;
    logic [LvlW-1:0]      level;
    logic                 overflow;
    logic                 flag;
    logic [INST_BITS-1:0] instruction;
    logic                 inst_valid;
    logic                 drained;
    logic                 timeout;
`ifdef SA_INST_ISSUER_COUNT_EN
    logic [31:0]          issued_cnt;

    modport master (
        output wr_en, wr_inst, flush, flag,
        input  full, level, overflow, instruction, inst_valid, drained, timeout, issued_cnt
    );

    modport slave (
        input  wr_en, wr_inst, flush, flag,
        output full, level, overflow, instruction, inst_valid, drained, timeout, issued_cnt
    );
`else
    modport master (
        output wr_en, wr_inst, flush, flag,
        input  full, level, overflow, instruction, inst_valid, drained, timeout
    );

    modport slave (
        input  wr_en, wr_inst, flush, flag,
        output full, level, overflow, instruction, inst_valid, drained, timeout
    );
`endif
endinterface

// File: rtl/sa_inst_issuer.sv
// Instruction issuer: queues host words and presents one per array slot (flag high, then low).
// Optional issued-word counter enabled by defining SA_INST_ISSUER_COUNT_EN.
module sa_inst_issuer #(
    parameter int unsigned          INST_BITS      = 32,
    parameter int unsigned          DEPTH          = 16,
    parameter logic [INST_BITS-1:0] IDLE_INST      = '0,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             reset,
    sa_inst_issuer_if.slave host_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned WdW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WdW-1:0]  WdMax = WdW'(TIMEOUT_CYCLES);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    localparam logic [0:0] StWaitHi = 1'b0;
    localparam logic [0:0] StWaitLo = 1'b1;

    logic [INST_BITS-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 tmo_q, tmo_d;
    logic                 flag_q;
    logic [0:0]           state_q, state_d;
    logic [WdW-1:0]       wd_q, wd_d;

    logic full, empty, boundary, pop, push, push_drop;

    assign full     = (level_q == LvlFull);
    assign empty    = (level_q == '0);
    // Slot ends on the first low sample after the flag was seen high.
    assign boundary = (state_q == StWaitLo) && flag_q && !host_io.flag;
    assign pop      = boundary && !empty && !host_io.flush;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push      = host_io.wr_en && !host_io.flush && (!full || pop);
    assign push_drop = host_io.wr_en && !host_io.flush && full && !pop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitHi: if (host_io.flag) state_d = StWaitLo;
            StWaitLo: if (boundary)     state_d = StWaitHi;
            default:                    state_d = StWaitHi;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (host_io.flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    always_comb begin
        inst_d  = inst_q;
        valid_d = valid_q;
        if (boundary) begin
            if (pop) begin
                inst_d  = mem_q[rd_ptr_q];
                valid_d = 1'b1;
            end else begin
                inst_d  = IDLE_INST;
                valid_d = 1'b0;
            end
        end
    end

    assign ovf_d = ovf_q | push_drop;

    always_comb begin
        wd_d  = wd_q;
        tmo_d = tmo_q;
        if (TIMEOUT_CYCLES != 0) begin
            if (host_io.flag != flag_q) begin
                wd_d = '0;
            end else if (wd_q != WdMax) begin
                wd_d = wd_q + WdW'(1);
            end
            if ((wd_q == WdMax) && valid_q) tmo_d = 1'b1;
        end else begin
            wd_d = '0;
        end
        if (host_io.flush) tmo_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StWaitHi;
            flag_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            inst_q   <= IDLE_INST;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= host_io.flag;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            wd_q     <= wd_d;
        end
    end

    // Storage needs no reset: entries are only read when level says they were written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_io.wr_inst;
    end

`ifdef SA_INST_ISSUER_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 32'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign host_io.issued_cnt = cnt_q;
`endif

    assign host_io.full        = full;
    assign host_io.level       = level_q;
    assign host_io.overflow    = ovf_q;
    assign host_io.instruction = inst_q;
    assign host_io.inst_valid  = valid_q;
    assign host_io.drained     = empty && !valid_q;
    assign host_io.timeout     = tmo_q;

    a_level_bound: assert property (@(posedge clk) disable iff (reset) level_q <= LvlFull);
    a_ptr_level:   assert property (@(posedge clk) disable iff (reset)
                                    full || (LvlW'(PtrW'(wr_ptr_q - rd_ptr_q)) == level_q));
    a_push_excl:   assert property (@(posedge clk) disable iff (reset) !(push && push_drop));
endmodule

// File: tb/tb_sa_inst_issuer.sv
// Randomized and directed bench for sa_inst_issuer against a queue-based slot model.
module tb_sa_inst_issuer;
    localparam int unsigned INST_BITS = 32;
    localparam int unsigned DEPTH     = 16;
    localparam logic [31:0] IDLE      = 32'h0000_0013;
    localparam int unsigned TMO       = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sa_inst_issuer_if #(.INST_BITS(INST_BITS), .DEPTH(DEPTH)) bus ();

    sa_inst_issuer #(
        .INST_BITS      (INST_BITS),
        .DEPTH          (DEPTH),
        .IDLE_INST      (IDLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .host_io (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: a queue of pending words plus the currently presented one.
    logic [31:0] mq[$];
    logic [31:0] m_inst  = IDLE;
    bit          m_valid = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_tmo   = 1'b0;
    bit          m_prev  = 1'b0;
    int unsigned m_idle  = 0;
    logic [31:0] m_cnt   = 32'd0;

    function automatic void m_reset();
        mq.delete();
        m_inst  = IDLE;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_tmo   = 1'b0;
        m_prev  = 1'b0;
        m_idle  = 0;
        m_cnt   = 32'd0;
    endfunction

    function automatic void m_step();
        bit bnd;
        bit tmo_hit;
        bnd     = m_prev && !bus.flag;
        tmo_hit = (m_idle == TMO) && m_valid;
        if (bnd) begin
            if (!bus.flush && mq.size() > 0) begin
                m_inst  = mq.pop_front();
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end else begin
                m_inst  = IDLE;
                m_valid = 1'b0;
            end
        end
        if (bus.wr_en && !bus.flush) begin
            if (mq.size() < DEPTH) mq.push_back(bus.wr_inst);
            else                   m_ovf = 1'b1;
        end
        if (bus.flush) mq.delete();
        if (tmo_hit)   m_tmo = 1'b1;
        if (bus.flush) m_tmo = 1'b0;
        if (bus.flag != m_prev) m_idle = 0;
        else if (m_idle < TMO)  m_idle = m_idle + 1;
        m_prev = bus.flag;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    always @(posedge clk) begin
        #1;
        check("instruction", bus.instruction, m_inst);
        check("inst_valid", bus.inst_valid, m_valid);
        check("level", bus.level, mq.size());
        check("full", bus.full, mq.size() == DEPTH);
        check("overflow", bus.overflow, m_ovf);
        check("drained", bus.drained, (mq.size() == 0) && !m_valid);
        check("timeout", bus.timeout, m_tmo);
`ifdef SA_INST_ISSUER_COUNT_EN
        check("issued_cnt", bus.issued_cnt, m_cnt);
`endif
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_inst = w;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.flag = 1'b1;
        repeat (hi) step();
        bus.flag = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] words [4];
        int          lvls  [4];
        logic [31:0] prev;
        int          run;

        bus.wr_en   = 1'b0;
        bus.wr_inst = '0;
        bus.flush   = 1'b0;
        bus.flag    = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        check("rst_instruction", bus.instruction, IDLE);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_level", bus.level, 0);
        check("rst_full", bus.full, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_drained", bus.drained, 1'b1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            pulse(3, 5);
            check("idle_inst", bus.instruction, IDLE);
            check("idle_valid", bus.inst_valid, 1'b0);
            check("idle_drained", bus.drained, 1'b1);
        end

        push(32'h11);
        push(32'h22);
        push(32'h33);
        check("seq_level0", bus.level, 3);
        words = '{32'h11, 32'h22, 32'h33, IDLE};
        lvls  = '{2, 1, 0, 0};
        prev  = IDLE;
        for (int i = 0; i < 4; i++) begin
            bus.flag = 1'b1;
            repeat (3) step();
            bus.flag = 1'b0;
            check("seq_stable_hi", bus.instruction, prev);
            step();
            check("seq_issue", bus.instruction, words[i]);
            check("seq_level", bus.level, lvls[i]);
            repeat (4) step();
            prev = words[i];
        end
`ifdef SA_INST_ISSUER_COUNT_EN
        check("seq_issued_cnt", bus.issued_cnt, 3);
`endif

        for (int i = 0; i < 16; i++) push(32'h100 + i);
        check("full_flag", bus.full, 1'b1);
        check("full_level", bus.level, 16);
        check("full_no_ovf", bus.overflow, 1'b0);
        push(32'hDEAD);
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_level", bus.level, 16);
        bus.flag = 1'b1;
        repeat (3) step();
        bus.flag    = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_inst = 32'hBEEF;
        step();
        bus.wr_en = 1'b0;
        check("pushpop_level", bus.level, 16);
        check("pushpop_inst", bus.instruction, 32'h100);
        repeat (4) step();
        for (int i = 0; i < 15; i++) pulse(3, 5);
        check("drain_last_old", bus.instruction, 32'h10F);
        pulse(3, 5);
        check("drain_beef", bus.instruction, 32'hBEEF);

        do_reset();
        for (int i = 0; i < 5; i++) push(32'h51 + i);
        pulse(3, 5);
        check("fl_pre_inst", bus.instruction, 32'h51);
        check("fl_pre_level", bus.level, 4);
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_inst = 32'h99;
        step();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        check("fl_level", bus.level, 0);
        check("fl_ovf", bus.overflow, 1'b0);
        check("fl_hold_inst", bus.instruction, 32'h51);
        check("fl_hold_valid", bus.inst_valid, 1'b1);
        pulse(3, 5);
        check("fl_idle_inst", bus.instruction, IDLE);
        check("fl_idle_valid", bus.inst_valid, 1'b0);
        push(32'h61);
        pulse(3, 5);
        push(32'h62);
        bus.flag = 1'b1;
        repeat (3) step();
        bus.flag  = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fl_bnd_inst", bus.instruction, IDLE);
        check("fl_bnd_level", bus.level, 0);

        do_reset();
        push(32'h44);
        bus.flag = 1'b1;
        repeat (3) step();
        bus.flag = 1'b0;
        step();
        check("wd_inst", bus.instruction, 32'h44);
        repeat (1000) step();
        check("wd_early", bus.timeout, 1'b0);
        repeat (30) step();
        check("wd_fired", bus.timeout, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("wd_flush_clr", bus.timeout, 1'b0);

        do_reset();
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 45);
            bus.wr_inst = $urandom();
            bus.flush   = ($urandom_range(0, 199) == 0);
            if (run == 0) begin
                bus.flag = ~bus.flag;
                run      = $urandom_range(1, 6);
            end
            run--;
            step();
        end
        bus.wr_en = 1'b0;
        bus.flush = 1'b0;
        bus.flag  = 1'b0;
        repeat (3) step();

        do_reset();
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        pulse(3, 5);
        check("mid_pre_inst", bus.instruction, 32'hA0);
        check("mid_pre_level", bus.level, 3);
        bus.flag = 1'b1;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("mid_inst", bus.instruction, IDLE);
        check("mid_level", bus.level, 0);
        check("mid_valid", bus.inst_valid, 1'b0);
`ifdef SA_INST_ISSUER_COUNT_EN
        check("mid_issued_cnt", bus.issued_cnt, 0);
`endif
        bus.flag = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sa_inst_issuer.md
Name: sa_inst_issuer

Overview:
- Hardware instruction issuer for SYSTOLIC_ARRAY; the producer end of the array's instruction/flag slot handshake.
- A host (CPU, DMA or controller) pushes instruction words into an internal FIFO.
- The block presents one instruction per array slot and advances at each slot boundary: flag rises, then falls.
- When nothing is queued it presents IDLE_INST. Replaces the hand-sequenced instruction stream in sequencing benches and firmware.

Parameters:
- INST_BITS, 32, instruction word width; must equal the array's instruction width.
- DEPTH, 16, FIFO depth in entries; power of two, >= 2.
- IDLE_INST, 0, full instruction word issued when the FIFO is empty.
- TIMEOUT_CYCLES, 1024, max cycles without a flag edge before timeout is set; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_inst into the FIFO.
- wr_inst  in  INST_BITS  instruction word to queue.
- flush  in  1  synchronous; discards all queued entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH)+1  number of queued entries.
- overflow  out  1  sticky: a push was attempted while full.
- flag  in  1  slot flag from the array.
- instruction  out  INST_BITS  registered instruction driven to the array.
- inst_valid  out  1  high while instruction came from the FIFO; low while it is IDLE_INST.
- drained  out  1  level==0 and inst_valid==0.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, active-high) values:
  - instruction=IDLE_INST, inst_valid=0, level=0, full=0, overflow=0, timeout=0, drained=1.
  - Internal state=WAIT_HI, flag_q=0, watchdog counter=0.
- flag is sampled into flag_q every cycle. There is no synchronizer; flag is synchronous to clk.
- FSM, two states:
  - WAIT_HI: go to WAIT_LO when flag==1.
  - WAIT_LO: a slot boundary occurs on the edge where flag_q==1 and flag==0. On that edge, go back to WAIT_HI and load the next instruction.
- Load at a slot boundary:
  - If level>0: instruction <= FIFO head, pop, inst_valid<=1.
  - Else: instruction <= IDLE_INST, inst_valid<=0.
- instruction changes only at slot boundaries, exactly 1 cycle after flag is first seen low.
- FIFO is circular, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Push with full==1: the word is dropped and overflow is set. overflow clears only on reset.
- Push and pop in the same cycle:
  - Both occur and level is unchanged.
  - If full, the pop frees a slot first, so the push is accepted.
- Push into an empty FIFO on a boundary cycle: the boundary issues IDLE_INST. The pushed word is issued at the next boundary.
- flush:
  - Sets level=0 and pointers equal.
  - The currently presented instruction is not changed.
  - flush wins over a push in the same cycle; that push is discarded without setting overflow.
  - flush on a boundary cycle issues IDLE_INST.
- Watchdog:
  - The counter clears on any change of flag (flag != flag_q) and otherwise increments, saturating.
  - timeout is set when the counter reaches TIMEOUT_CYCLES while inst_valid==1.
  - timeout clears on reset or flush.
- Reset mid-slot: all state returns to reset values at once and queued instructions are lost.

Optional Feature:
- Macro: SA_INST_ISSUER_COUNT_EN.
- Defined:
  - Adds output issued_cnt, 32 bits, reset 0.
  - Increments at every boundary that pops a FIFO entry; IDLE_INST issues are not counted.
  - Wraps at 2^32 and is not cleared by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle toggling: 4 flag pulses with nothing queued -> instruction==IDLE_INST, inst_valid=0, drained=1 throughout.
- Sequential issue:
  - Stimulus: push 0x11, 0x22, 0x33, then 4 flag pulses (high 3 cycles, low 5 cycles).
  - Response: instruction is 0x11, 0x22, 0x33, then IDLE_INST.
  - Each change occurs 1 cycle after flag falls, is stable while flag is high, and level goes 3→2→1→0.
- Full/overflow:
  - Stimulus: push DEPTH(16) words.
  - Response: full=1, level=16. A 17th push sets overflow=1 and the word is not issued.
  - Then push and boundary in the same cycle -> level stays 16 and the new word is accepted.
- Flush:
  - Stimulus: queue 5 words, issue 1, assert flush.
  - Response: level=0. The current instruction is held until the boundary, then IDLE_INST is issued.
  - A push in the flush cycle is dropped with overflow=0.
- Watchdog: queue 0x44, hold flag low 1024 cycles after issue -> timeout=1 at cycle 1024; flush clears it.
- Reset mid-slot: assert reset while flag==1 and level=3 -> instruction=IDLE_INST, level=0 immediately (async); issued_cnt=0 when SA_INST_ISSUER_COUNT_EN is defined.
